mc_ctrl: RTL and testbench

Multi-cycle control unit for the MIPS datapath. It sequences each instruction through fetch, decode, execute, memory and writeback states. It drives the program-counter write enable and next-PC select, the instruction-register load, the register-file and data-memory write strobes, and all datapath mux selects. It sits beside the PC register and the NPC logic and is the only source of `PCWr`.

---
 rtl/mc_ctrl_pkg.sv | 26 ++
 rtl/mc_ctrl_decode.sv | 23 ++
 rtl/mc_ctrl.sv | 68 ++++++
 tb/tb_mc_ctrl.sv | 106 ++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared opcode/funct constants, state encodings, mux encodings and decode class flags
package mc_ctrl_pkg;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] F_ADDU  = 6'b100001;
  localparam logic [5:0] F_SUBU  = 6'b100011;
  localparam logic [5:0] F_JR    = 6'b001000;
  localparam logic [1:0] NPC_PC4 = 2'b00, NPC_BR  = 2'b01, NPC_J   = 2'b10, NPC_JR  = 2'b11;
  localparam logic [1:0] ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_OR  = 2'b10, ALU_B   = 2'b11;
  localparam logic [1:0] EXT_Z   = 2'b00, EXT_S   = 2'b01, EXT_LUI = 2'b10;
  localparam logic [1:0] RD_RT   = 2'b00, RD_RD   = 2'b01, RD_31   = 2'b10;
  localparam logic [1:0] WD_ALU  = 2'b00, WD_DM   = 2'b01, WD_PC4  = 2'b10;
  typedef enum logic [3:0] {
    S_FETCH = 4'd0, S_DECODE = 4'd1, S_MA = 4'd2, S_MR = 4'd3, S_MW = 4'd4,
    S_WBM = 4'd5, S_EXE = 4'd6, S_WBA = 4'd7, S_BR = 4'd8, S_JMP = 4'd9
  } state_t;
  typedef struct packed {
    logic rtype_alu, ori, lui, lw, sw, beq, j, jal, jr, undef;
  } cls_t;
endpackage

// File: rtl/mc_ctrl_decode.sv
// mc_decode: maps Op/Funct to one-hot instruction class flags (Op, Funct in; cls out)
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  output cls_t       cls
);
  logic rtype;
  always_comb begin
    rtype         = Op == OP_R;
    cls.rtype_alu = rtype && (Funct == F_ADDU || Funct == F_SUBU);
    cls.jr        = rtype && Funct == F_JR;
    cls.ori       = Op == OP_ORI;
    cls.lui       = Op == OP_LUI;
    cls.lw        = Op == OP_LW;
    cls.sw        = Op == OP_SW;
    cls.beq       = Op == OP_BEQ;
    cls.j         = Op == OP_J;
    cls.jal       = Op == OP_JAL;
    cls.undef     = !(cls.rtype_alu || cls.jr || cls.ori || cls.lui || cls.lw || cls.sw || cls.beq || cls.j || cls.jal);
  end
endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS control FSM (Clk, Reset active-low async, Op/Funct/Zero in; PC/IR/RF/DM strobes, mux selects, State out)
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [5:0]         Op,
  input  logic [5:0]         Funct,
  input  logic               Zero,
  output logic               PCWr,
  output logic [1:0]         NPCOp,
  output logic               IRWr,
  output logic               RFWr,
  output logic               DMWr,
  output logic [1:0]         ALUOp,
  output logic [1:0]         ExtOp,
  output logic               BSel,
  output logic [1:0]         RegDst,
  output logic [1:0]         WDSel,
  output logic [STATE_W-1:0] State
);
  state_t st;
  cls_t   c;
  mc_decode u_dec (.Op(Op), .Funct(Funct), .cls(c));
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) st <= S_FETCH;
    else
      case (st)
        S_FETCH:  st <= S_DECODE;
        S_DECODE: st <= (c.lw || c.sw) ? S_MA :
                        (c.rtype_alu || c.ori || c.lui) ? S_EXE :
                        c.beq ? S_BR :
                        (c.j || c.jal || c.jr) ? S_JMP : S_FETCH;
        S_MA:     st <= c.lw ? S_MR : S_MW;
        S_MR:     st <= S_WBM;
        S_EXE:    st <= S_WBA;
        default:  st <= S_FETCH;
      endcase
  always_comb begin
    {PCWr, NPCOp, IRWr, RFWr, DMWr, ALUOp, ExtOp, BSel, RegDst, WDSel} = '0;
    case (st)
      S_FETCH: {PCWr, IRWr} = 2'b11;
      S_MA:    {ALUOp, ExtOp, BSel} = {ALU_ADD, EXT_S, 1'b1};
      S_MW:    DMWr = 1'b1;
      S_WBM:   {RFWr, RegDst, WDSel} = {1'b1, RD_RT, WD_DM};
      S_EXE, S_WBA: begin
        ALUOp  = c.rtype_alu ? (Funct == F_SUBU ? ALU_SUB : ALU_ADD) : c.ori ? ALU_OR : ALU_B;
        ExtOp  = c.lui ? EXT_LUI : EXT_Z;
        BSel   = !c.rtype_alu;
        RFWr   = st == S_WBA;
        RegDst = (st == S_WBA && c.rtype_alu) ? RD_RD : RD_RT;
      end
      S_BR:    {ALUOp, NPCOp, PCWr} = {ALU_SUB, NPC_BR, Zero};
      S_JMP: begin
        PCWr   = 1'b1;
        NPCOp  = c.jr ? NPC_JR : NPC_J;
        RFWr   = c.jal;
        RegDst = c.jal ? RD_31 : RD_RT;
        WDSel  = c.jal ? WD_PC4 : WD_ALU;
      end
      default: ;
    endcase
    if (!Reset) {PCWr, IRWr, RFWr, DMWr} = '0;
  end
  assign State = STATE_W'(st);
endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: table-driven check of mc_ctrl state sequences and per-state outputs, plus reset corner cases
module tb_mc_ctrl;
  logic       Clk = 1'b0, Reset = 1'b1, Zero = 1'b0;
  logic [5:0] Op = '0, Funct = '0;
  logic       PCWr, IRWr, RFWr, DMWr, BSel;
  logic [1:0] NPCOp, ALUOp, ExtOp, RegDst, WDSel;
  logic [3:0] State;
  int         n_chk = 0, n_pass = 0;
  typedef struct {
    logic [5:0]  op, fn;
    logic        z;
    logic [18:0] exp;
  } vec_t;
  vec_t q[$];
  mc_ctrl #(.STATE_W(4)) dut (
    .Clk(Clk), .Reset(Reset), .Op(Op), .Funct(Funct), .Zero(Zero),
    .PCWr(PCWr), .NPCOp(NPCOp), .IRWr(IRWr), .RFWr(RFWr), .DMWr(DMWr),
    .ALUOp(ALUOp), .ExtOp(ExtOp), .BSel(BSel), .RegDst(RegDst), .WDSel(WDSel), .State(State)
  );
  always #5 Clk = ~Clk;
  function automatic vec_t r(input logic [5:0] op, fn, input logic z, input logic [3:0] st,
                             input logic pcwr, input logic [1:0] npc, input logic irwr, rfwr, dmwr,
                             input logic [1:0] alu, ext, input logic bsel, input logic [1:0] rd, wd);
    vec_t v;
    v.op = op;
    v.fn = fn;
    v.z = z;
    v.exp = {st, pcwr, npc, irwr, rfwr, dmwr, alu, ext, bsel, rd, wd};
    return v;
  endfunction
  function automatic logic [18:0] act();
    return {State, PCWr, NPCOp, IRWr, RFWr, DMWr, ALUOp, ExtOp, BSel, RegDst, WDSel};
  endfunction
  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, a, e);
  endtask
  task automatic fd(input logic [5:0] op, fn);
    q.push_back(r(op, fn, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    q.push_back(r(op, fn, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask
  initial begin
    fd(6'h23, 0);
    q.push_back(r(6'h23, 0, 0, 2, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    q.push_back(r(6'h23, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    q.push_back(r(6'h23, 0, 0, 5, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1));
    fd(6'h2b, 0);
    q.push_back(r(6'h2b, 0, 0, 2, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    q.push_back(r(6'h2b, 0, 0, 4, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    fd(6'h00, 6'h21);
    q.push_back(r(6'h00, 6'h21, 0, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    q.push_back(r(6'h00, 6'h21, 0, 7, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0));
    fd(6'h00, 6'h23);
    q.push_back(r(6'h00, 6'h23, 0, 6, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    q.push_back(r(6'h00, 6'h23, 0, 7, 0, 0, 0, 1, 0, 1, 0, 0, 1, 0));
    fd(6'h0d, 0);
    q.push_back(r(6'h0d, 0, 0, 6, 0, 0, 0, 0, 0, 2, 0, 1, 0, 0));
    q.push_back(r(6'h0d, 0, 0, 7, 0, 0, 0, 1, 0, 2, 0, 1, 0, 0));
    fd(6'h0f, 0);
    q.push_back(r(6'h0f, 0, 0, 6, 0, 0, 0, 0, 0, 3, 2, 1, 0, 0));
    q.push_back(r(6'h0f, 0, 0, 7, 0, 0, 0, 1, 0, 3, 2, 1, 0, 0));
    fd(6'h04, 0);
    q.push_back(r(6'h04, 0, 1, 8, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0));
    fd(6'h04, 0);
    q.push_back(r(6'h04, 0, 0, 8, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0));
    fd(6'h02, 0);
    q.push_back(r(6'h02, 0, 0, 9, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0));
    fd(6'h03, 0);
    q.push_back(r(6'h03, 0, 0, 9, 1, 2, 0, 1, 0, 0, 0, 0, 2, 2));
    fd(6'h00, 6'h08);
    q.push_back(r(6'h00, 6'h08, 0, 9, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0));
    fd(6'h3f, 0);
    fd(6'h23, 0);
    #1 Reset = 1'b0;
    #1 chk("reset_state", 32'(State), 0);
    chk("reset_strobes", {PCWr, IRWr, RFWr, DMWr}, 0);
    @(posedge Clk);
    #1 Reset = 1'b1;
    foreach (q[i]) begin
      Op = q[i].op;
      Funct = q[i].fn;
      Zero = q[i].z;
      @(negedge Clk);
      chk($sformatf("row%0d_op%h_st%0d", i, q[i].op, q[i].exp[18:15]), 32'(act()), 32'(q[i].exp));
      @(posedge Clk);
      #1;
    end
    Op = 6'h23;
    Zero = 1'b0;
    @(posedge Clk);
    #1 chk("lw_mid_mr_state", 32'(State), 3);
    #2 Reset = 1'b0;
    #1 chk("async_reset_state", 32'(State), 0);
    chk("async_reset_strobes", {PCWr, IRWr, RFWr, DMWr}, 0);
    @(posedge Clk);
    #1 chk("held_reset_state", 32'(State), 0);
    chk("held_reset_strobes", {PCWr, IRWr, RFWr, DMWr}, 0);
    Reset = 1'b1;
    #1 chk("release_fetch", {State, PCWr, IRWr, RFWr, DMWr}, 8'b0000_1100);
    @(posedge Clk);
    #1 chk("post_release_decode", 32'(State), 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
